// File: rtl/a3_ex_wb_stage.sv
// Execute stage plus EX/WB pipeline register: forms the write-back value (sext immediate or sum)
// and resolves the rs1 RAW hazard against EX/WB. Optional forwarding: define EX_WB_FORWARD_EN.
module a3_ex_wb_stage #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int IMM_W  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              SEtoReg_in,
   input  logic              WriteReg_in,
   input  logic [ADDR_W-1:0] rs1_in,
   input  logic [ADDR_W-1:0] rd_in,
   input  logic [DATA_W-1:0] data1_in,
   input  logic [DATA_W-1:0] data2_in,
   input  logic [IMM_W-1:0]  unextended_in,
   output logic              WriteReg_out,
   output logic [ADDR_W-1:0] rd_out,
   output logic [DATA_W-1:0] result_out,
   output logic              fwd_hit
);

   logic              we_q, we_d;
   logic [ADDR_W-1:0] rd_q, rd_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic [DATA_W-1:0] sext;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] sum;

   // Replication count would be zero when the immediate already spans the datapath.
   generate
      if (IMM_W < DATA_W) begin : g_sext
         assign sext = {{(DATA_W-IMM_W){unextended_in[IMM_W-1]}}, unextended_in};
      end else begin : g_noext
         assign sext = unextended_in;
      end
   endgenerate

`ifdef EX_WB_FORWARD_EN
   logic match;
   // The held EX/WB contents are the forwarding source, including while stalled.
   assign match   = we_q && (rd_q == rs1_in);
   assign op_a    = match ? res_q : data1_in;
   assign fwd_hit = match && !SEtoReg_in;
`else
   assign op_a    = data1_in;
   assign fwd_hit = 1'b0;
`endif

   assign sum = op_a + data2_in;

   always_comb begin
      we_d  = we_q;
      rd_d  = rd_q;
      res_d = res_q;
      if (!stall) begin
         we_d  = WriteReg_in;
         rd_d  = rd_in;
         res_d = SEtoReg_in ? sext : sum;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we_q  <= 1'b0;
         rd_q  <= '0;
         res_q <= '0;
      end else begin
         we_q  <= we_d;
         rd_q  <= rd_d;
         res_q <= res_d;
      end
   end

   assign WriteReg_out = we_q;
   assign rd_out       = rd_q;
   assign result_out   = res_q;

endmodule
